dmem_bridge: RTL
================

# dmem_bridge

Data-memory bridge between the core's load/store port and a single-outstanding valid/ready memory bus. It captures a core access request, runs one bus transaction, and returns load data. It holds the core with `stall` until the access completes, so a variable-latency memory can replace the zero-wait combinational data RAM. It sits directly downstream of the core's `mem_out`/`mem_read_out`/`addr`/`data_out` outputs and drives the core's `data_in`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; word accesses only
- `TIMEOUT`, 255, maximum cycles spent in REQ+WAIT before abort (used only with `DMEM_BRIDGE_TIMEOUT_EN`)

Ports:
- `clk`  in  1  sole clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `core_mem`  in  1  core access request, held high while pending
- `core_read`  in  1  1 = load, 0 = store; valid with `core_mem`
- `core_addr`  in  ADDR_W  byte address
- `core_wdata`  in  DATA_W  store data
- `core_rdata`  out  DATA_W  registered load result
- `stall`  out  1  core must hold its state and request
- `err`  out  1  one-cycle pulse in DONE on misaligned access or timeout
- `bus_req`  out  1  bus request valid
- `bus_we`  out  1  bus write enable
- `bus_addr`  out  ADDR_W  bus address, word aligned
- `bus_wdata`  out  DATA_W  bus write data
- `bus_ready`  in  1  bus accepts request when `bus_req && bus_ready`
- `bus_rvalid`  in  1  read data valid; no earlier than the cycle after acceptance
- `bus_rdata`  in  DATA_W  read data

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - With `core_mem`=1 and aligned `core_addr[1:0]`=0, capture addr, wdata and read into internal registers, then go to REQ.
  - With `core_mem`=1 and misaligned, go to DONE with `err` set; no bus transaction; `core_rdata` set to 0.
- REQ: `bus_req`=1 and the bus outputs are driven from the captured registers, stable until accepted. On `bus_ready`: a write goes to DONE; a read goes to WAIT.
- WAIT: on `bus_rvalid`, register `bus_rdata` into `core_rdata` and go to DONE.
- DONE: lasts one cycle, then IDLE. A still-high `core_mem` in the following IDLE cycle is a new request (back-to-back).
- `stall` = `core_mem` && state != DONE. It is combinational on `core_mem` in IDLE, so the core never advances on the request cycle.
- `bus_rvalid` outside WAIT is ignored.
- `core_rdata` keeps its value except on read completion, misalignment (0), or timeout (0).
- `core_*` inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE; `bus_req`=0; `bus_we`=0; `bus_addr`=0; `bus_wdata`=0; `core_rdata`=0; `err`=0; timeout counter 0. `stall` follows `core_mem` in IDLE.
- Reset mid-transaction returns to IDLE next edge and drops `bus_req` immediately. A late `bus_rvalid` is dropped.
- Write with ready already high: request edge → REQ (1 cycle) → DONE. `stall` is high for 2 cycles.
- Read with ready high and rvalid one cycle later: IDLE → REQ → WAIT → DONE. `stall` is high for 3 cycles; `core_rdata` is valid in DONE.
- Misaligned: IDLE → DONE. `stall` is high for 1 cycle; `err` is high in DONE.
- Simultaneous `rst` and any event: reset wins.

## Configuration
- `DMEM_BRIDGE_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entering REQ and increments each cycle in REQ/WAIT.
  - When the counter equals `TIMEOUT` and no completion occurs that cycle, go to DONE with `err`=1 and `core_rdata`=0, dropping `bus_req`.
  - Completion in the same cycle as the timeout wins over the timeout.
- Undefined: no counter; REQ/WAIT wait indefinitely; `err` only signals misalignment; `TIMEOUT` is unused.

## Structure
- Shared package `dmem_pkg`: state enum (IDLE/REQ/WAIT/DONE), `WORD_BYTES`=4, alignment mask constant.
- One sub-module, `dmem_timeout`, holds the counter and compare; it is instantiated only under `DMEM_BRIDGE_TIMEOUT_EN`.

## Test plan
- Aligned store addr 0x100, wdata 0xCAFEF00D, ready high → `bus_req` for 1 cycle with `bus_we`=1, addr 0x100; `stall` high for 2 cycles; `err`=0.
- Aligned load addr 0x204, ready delayed 3 cycles, rvalid 2 cycles after accept with 0x12345678 → `core_rdata`=0x12345678 in DONE; bus outputs stable during the wait.
- Misaligned load addr 0x103 → no `bus_req`; `err` pulse; `core_rdata`=0; `stall` high for 1 cycle.
- Two back-to-back loads (0x10 then 0x14) with `core_mem` held high → two distinct bus transactions, each followed by a single DONE cycle.
- `rst` asserted in WAIT, with rvalid arriving after reset → state IDLE, `bus_req`=0, `core_rdata`=0, late data ignored.
- Timeout build, `TIMEOUT`=4, ready never asserted → DONE after 5 REQ/WAIT cycles with `err`=1. Non-timeout build: `stall` stays high indefinitely.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared state encoding and word-alignment helpers for the data-memory bridge.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } dmem_state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ALIGN_BITS = $clog2(WORD_BYTES);
    localparam logic [ALIGN_BITS-1:0] ALIGN_MASK = ALIGN_BITS'(WORD_BYTES - 1);

    function automatic logic is_aligned(input logic [ALIGN_BITS-1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == '0;
    endfunction

endpackage

// File: rtl/dmem_timeout.sv
// Watchdog for a pending bus transaction: counts cycles spent in REQ/WAIT and flags when the
// count reaches TIMEOUT. Only instantiated when DMEM_BRIDGE_TIMEOUT_EN is defined.
module dmem_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_active,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    assign w_expired = (r_cnt == CNT_W'(TIMEOUT));

    // Holding at TIMEOUT keeps the counter from wrapping if the owner lingers for a cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_start) begin
            r_cnt <= '0;
        end else if (i_active && !w_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = w_expired;

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's zero-wait load/store port onto a single-outstanding valid/ready bus,
// stalling the core until each access completes. Define DMEM_BRIDGE_TIMEOUT_EN to abort hung
// transactions after TIMEOUT cycles in REQ/WAIT.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_core_mem,
    input  logic              i_core_read,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_stall,
    output logic              o_err,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic              i_bus_ready,
    input  logic              i_bus_rvalid,
    input  logic [DATA_W-1:0] i_bus_rdata
);

    dmem_state_e       r_state;
    dmem_state_e       w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_read;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_aligned;
    logic              w_start;
    logic              w_misalign;
    logic              w_accept;
    logic              w_rdone;
    logic              w_expired;
    logic              w_abort;

    assign w_aligned  = is_aligned(i_core_addr[ALIGN_BITS-1:0]);
    assign w_start    = (r_state == StIdle) && i_core_mem && w_aligned;
    assign w_misalign = (r_state == StIdle) && i_core_mem && !w_aligned;
    assign w_accept   = (r_state == StReq) && i_bus_ready;
    assign w_rdone    = (r_state == StWait) && i_bus_rvalid;

    // A completion landing on the expiry cycle takes priority over the abort.
    assign w_abort = w_expired &&
                     (((r_state == StReq) && !i_bus_ready) ||
                      ((r_state == StWait) && !i_bus_rvalid));

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic w_active;

    assign w_active = (r_state == StReq) || (r_state == StWait);

    dmem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (w_start),
        .i_active  (w_active),
        .o_expired (w_expired)
    );
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_expired        = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_core_mem) begin
                    w_state_next = w_aligned ? StReq : StDone;
                end
            end
            StReq: begin
                if (i_bus_ready) begin
                    w_state_next = r_read ? StWait : StDone;
                end else if (w_expired) begin
                    w_state_next = StDone;
                end
            end
            StWait: begin
                if (i_bus_rvalid || w_expired) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Request capture, load result and error flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_read  <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr  <= i_core_addr;
                r_wdata <= i_core_wdata;
                r_read  <= i_core_read;
            end
            if (w_rdone) begin
                r_rdata <= i_bus_rdata;
            end else if (w_misalign || w_abort) begin
                r_rdata <= '0;
            end
            // Every error path lands in DONE, which always lasts one cycle.
            r_err <= w_misalign || w_abort;
        end
    end

    // Outputs
    always_comb begin
        o_stall   = i_core_mem && (r_state != StDone);
        o_bus_req = 1'b0;
        o_bus_we  = 1'b0;
        if (r_state == StReq) begin
            // Reset withdraws the request in the same cycle so the bus cannot accept it.
            o_bus_req = !i_rst;
            o_bus_we  = !r_read;
        end
    end

    assign o_bus_addr   = r_addr;
    assign o_bus_wdata  = r_wdata;
    assign o_core_rdata = r_rdata;
    assign o_err        = r_err;

endmodule
